// File: rtl/int_divider.sv
// Iterative restoring 64-bit divider (RV64M DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional macro INT_DIVIDER_DIV0_FAST_EN: divide-by-zero bypasses the iterations.
module int_divider #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              start_ready,
  input  logic              op_signed,
  input  logic              op_rem,
  input  logic [XLEN-1:0]   dividend,
  input  logic [XLEN-1:0]   divisor,
  input  logic [REG_AW-1:0] dest_reg,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [XLEN-1:0]   result,
  output logic [REG_AW-1:0] result_reg
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_op_signed;
  logic              r_op_rem;
  logic [REG_AW-1:0] r_dest;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dvsr;
  logic              r_qneg;
  logic              r_rneg;
  logic              r_div0;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_result;
  logic [REG_AW-1:0] r_result_reg;

  logic            w_div0;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_dvnd_mag;
  logic [XLEN-1:0] w_dvsr_mag;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;

  assign w_div0  = (divisor == '0);
  assign w_a_neg = op_signed & dividend[XLEN-1];
  assign w_b_neg = op_signed & divisor[XLEN-1];

  // Dividend stays un-negated on divide-by-zero so the remainder comes out as the original value.
  assign w_dvnd_mag = (w_a_neg && !w_div0) ? -dividend : dividend;
  assign w_dvsr_mag = w_b_neg ? -divisor : divisor;

  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_dvsr};
  assign w_ge      = ~w_diff[XLEN];
  assign w_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};

  assign w_quo_fix = (r_op_signed && !r_div0 && r_qneg) ? -r_quo : r_quo;
  assign w_rem_fix = (r_op_signed && !r_div0 && r_rneg) ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start) begin
`ifdef INT_DIVIDER_DIV0_FAST_EN
          w_next = w_div0 ? S_DONE : S_BUSY;
`else
          w_next = S_BUSY;
`endif
        end
      end
      S_BUSY: if (r_cnt == '0) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: begin
        result_valid = 1'b1;
        if (result_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_signed  <= 1'b0;
      r_op_rem     <= 1'b0;
      r_dest       <= '0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_dvsr       <= '0;
      r_qneg       <= 1'b0;
      r_rneg       <= 1'b0;
      r_div0       <= 1'b0;
      r_cnt        <= '0;
      r_result     <= '0;
      r_result_reg <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op_signed <= op_signed;
            r_op_rem    <= op_rem;
            r_dest      <= dest_reg;
            r_rem       <= '0;
            r_quo       <= w_dvnd_mag;
            r_dvsr      <= w_dvsr_mag;
            r_qneg      <= w_a_neg ^ w_b_neg;
            r_rneg      <= w_a_neg;
            r_div0      <= w_div0;
            r_cnt       <= CW'(XLEN - 1);
`ifdef INT_DIVIDER_DIV0_FAST_EN
            if (w_div0) begin
              r_result     <= op_rem ? dividend : '1;
              r_result_reg <= dest_reg;
            end
`endif
          end
        end
        S_BUSY: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          r_result     <= r_op_rem ? w_rem_fix : w_quo_fix;
          r_result_reg <= r_dest;
        end
        default: ;
      endcase
    end
  end

  assign result     = r_result;
  assign result_reg = r_result_reg;

endmodule
